// File: rtl/alu_pkg.sv
// Shared ALU op codes, slot state encoding and op legality helper.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND   = 4'b0000;
    localparam alu_op_t ALU_OR    = 4'b0001;
    localparam alu_op_t ALU_ADD   = 4'b0010;
    localparam alu_op_t ALU_SUB   = 4'b0110;
    localparam alu_op_t ALU_PASSB = 4'b0111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    // True for the five op codes the ALU implements.
    function automatic logic is_legal_op(input alu_op_t op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU; illegal codes yield a zero result.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_op_t      ALUControl,
    output logic [N-1:0] result,
    output logic         zero
);

    // Operation select; arithmetic wraps modulo 2^N.
    always_comb begin
        result = '0;
        case (ALUControl)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters with a
// one-entry registered response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N     = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  alu_op_t          req0_op,
    input  alu_op_t          req1_op,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [N-1:0]     rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    slot_state_t  state, state_nxt;
    logic         ptr;
    logic         slot_free;
    logic         grant;
    logic         win;
    alu_op_t      win_op;
    logic [N-1:0] win_a, win_b;
    logic [N-1:0] alu_result;
    logic         alu_zero;

    assign rsp_valid = (state == ST_FULL);
    assign slot_free = !rsp_valid || rsp_ready;

    // Winner selection: lone requester wins, pointer breaks ties.
    always_comb begin
        win       = 1'b0;
        grant     = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            win = ptr;
        end else begin
            win = req_valid[1];
        end
        if (reset && slot_free && (req_valid != 2'b00)) begin
            grant     = 1'b1;
            req_ready = win ? 2'b10 : 2'b01;
        end
    end

    // Operand mux feeding the shared ALU.
    always_comb begin
        win_op = win ? req1_op : req0_op;
        win_a  = win ? req1_a  : req0_a;
        win_b  = win ? req1_b  : req0_b;
    end

    alu #(.N(N)) u_alu (
        .a          (win_a),
        .b          (win_b),
        .ALUControl (win_op),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    // Slot next-state: stay full under backpressure or on refill.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (grant) state_nxt = ST_FULL;
            ST_FULL: begin
                if (rsp_ready) state_nxt = grant ? ST_FULL : ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Response payload, loaded only on a grant so it holds under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (grant) begin
            rsp_id     <= win;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= !is_legal_op(win_op);
        end
    end

    // Round-robin pointer and per-requester grant counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant) begin
            ptr <= !win;
            if (win) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            else     grant_cnt0 <= grant_cnt0 + CNT_W'(1);
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 64-bit datapath ALU (AND/OR/ADD/SUB/pass-B, with zero flag) between two requesters, e.g. the EX stage and a multi-cycle address/branch helper.
- Requests use valid/ready handshakes. Winners are chosen round-robin.
- Each result is registered into a one-entry response slot, tagged with the requester id and held under backpressure.
- The ALU is instantiated combinationally inside; this block supplies all sequencing.

Parameters:
- N, 64, operand/result width.
- CNT_W, 16, width of per-requester grant counters (wrap-around).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; a transfer occurs when valid&ready.
- req0_op, req1_op  in  4 each  ALUControl code.
- req0_a, req0_b, req1_a, req1_b  in  N each  operands.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  N  ALU result.
- rsp_zero  out  1  ALU zero flag (result == 0).
- rsp_err  out  1  op code was illegal.
- grant_cnt0, grant_cnt1  out  CNT_W each  accepted requests per requester.

Behaviour:
- Reset (reset=0, async) sets: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, priority pointer=0 (requester 0 favoured), grant counters=0. req_ready is 0 while in reset.
- Legal op codes:
  - 4'b0000 AND
  - 4'b0001 OR
  - 4'b0010 ADD
  - 4'b0110 SUB
  - 4'b0111 pass b
- Any other op code is accepted normally but produces rsp_err=1, rsp_result=0, rsp_zero=1.
- Arithmetic is modulo 2^N. Overflow is truncated and no flag is raised.
- The slot can load when it is free: slot_free = !rsp_valid || rsp_ready.
- Arbitration is combinational, evaluated when slot_free:
  - Only one requester valid: that requester wins.
  - Both valid: the requester indicated by the priority pointer wins.
  - req_ready has at most one bit set (the winner). Both bits are 0 if slot_free=0 or no requester is valid.
- Priority pointer: after a grant to requester i, the pointer becomes !i. It is unchanged when no grant occurs.
- Latency: a request accepted in cycle t appears on rsp_* with rsp_valid=1 in cycle t+1, with the ALU evaluated on the operands sampled at t.
- Throughput: one response per cycle when rsp_ready is held at 1. Draining the slot and loading a new request in the same cycle is allowed, and the slot stays valid with the new data.
- Backpressure: while rsp_valid=1 and rsp_ready=0, every rsp_* output is held stable and req_ready=2'b00.
- FSM (2 states):
  - EMPTY: on grant → FULL.
  - FULL:
    - rsp_ready & grant → FULL (data replaced).
    - rsp_ready & no grant → EMPTY.
    - !rsp_ready → FULL.
  - rsp_valid is 1 exactly when the state is FULL.
- Grant counters increment by 1 on each accepted transfer of their requester and wrap from 2^CNT_W-1 to 0.
- A requester may drop valid before being granted; nothing is recorded for it.
- Reset asserted mid-operation discards any pending response immediately. The pointer and counters return to 0.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_op_t (logic [3:0]).
  - Constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_PASSB=4'b0111.
  - Function is_legal_op.
- Sub-module: the existing alu (ports a, b, ALUControl, result, zero) is instantiated once, fed by the winner's operands.
- Arbitration, FSM, slot register and counters stay in alu_arbiter.

Test Plan:
- Single requester, rsp_ready=1:
  - Stimulus: req0 ADD a=4781, b=1346.
  - Required: req_ready=01 the same cycle; the next cycle gives rsp_valid=1, id=0, result=6127, zero=0, err=0; grant_cnt0=1.
- Contention with round-robin:
  - Stimulus: both valid for 4 cycles, rsp_ready=1. req0 AND 2060&4512, req1 SUB 2108-2669.
  - Required: grants go 0,1,0,1. Responses are (id0, result 0, zero 1) and (id1, result -561, zero 0), alternating. Final counters are 2 and 2.
- Backpressure:
  - Stimulus: fill the slot with req1 OR 4249|3605, hold rsp_ready=0 for 3 cycles with req0 valid.
  - Required: result 7837 held stable, req_ready=00 throughout. When rsp_ready is raised, req0 is granted the same cycle.
- Overflow and illegal op:
  - Stimulus: ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=1; then op 4'b1111.
  - Required: first response is result 0, zero 1, err 0. Second response is err 1, result 0, zero 1.
- Reset mid-operation:
  - Stimulus: slot FULL with pointer=1, then assert reset asynchronously between clock edges.
  - Required: rsp_valid drops to 0 immediately and counters read 0. After release, with both requesters valid, requester 0 wins first.
- Counter wrap:
  - Stimulus: CNT_W=2, five grants to req0.
  - Required: grant_cnt0 sequence 1,2,3,0,1.
